axis_eth_fcs_check: RTL

//  Receive-side counterpart of the FCS generator: checks and strips the Ethernet FCS on an 8-bit AXI4-Stream.

---
 rtl/axis_eth_fcs_check.sv | 103 ++++++++++
 1 files changed

// File: rtl/axis_eth_fcs_check.sv
// Ethernet FCS checker/stripper on an 8-bit AXI4-Stream.
// A 4-byte delay line holds back the trailing FCS. Payload bytes are forwarded, and the last beat carries tuser for bad frames.
module axis_eth_fcs_check (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       error_bad_fcs,
    output logic       error_short_frame
);

    // Reflected CRC-32 update for one byte (Galois form, LSB first).
    function automatic logic [31:0] crc_byte(input logic [7:0] data, input logic [31:0] crc);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    logic [7:0]  d0, d1, d2, d3;
    logic [2:0]  cnt;
    logic [31:0] crc_state;
    logic [31:0] crc_next;
    logic [31:0] fcs_calc;
    logic [31:0] fcs_rx;
    logic        fcs_bad;
    logic        accept;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // The oldest held byte is payload whenever the line is full, so the CRC always folds d0.
    assign crc_next = crc_byte(d0, crc_state);
    assign fcs_calc = ~crc_next;
    assign fcs_rx   = {s_axis_tdata, d3, d2, d1};
    assign fcs_bad  = (fcs_calc != fcs_rx);

    always_ff @(posedge clk) begin
        if (rst) begin
            d0                <= 8'h00;
            d1                <= 8'h00;
            d2                <= 8'h00;
            d3                <= 8'h00;
            cnt               <= 3'd0;
            crc_state         <= 32'hFFFFFFFF;
            m_axis_tdata      <= 8'h00;
            m_axis_tvalid     <= 1'b0;
            m_axis_tlast      <= 1'b0;
            m_axis_tuser      <= 1'b0;
            error_bad_fcs     <= 1'b0;
            error_short_frame <= 1'b0;
        end else begin
            error_bad_fcs     <= 1'b0;
            error_short_frame <= 1'b0;

            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (accept) begin
                if (!s_axis_tlast) begin
                    d0 <= d1;
                    d1 <= d2;
                    d2 <= d3;
                    d3 <= s_axis_tdata;
                    if (cnt == 3'd4) begin
                        m_axis_tdata  <= d0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                        crc_state     <= crc_next;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end else begin
                    // Last beat: finish the frame, or drop it as short if it never filled the delay line.
                    if (cnt == 3'd4) begin
                        m_axis_tdata  <= d0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        m_axis_tuser  <= fcs_bad || s_axis_tuser;
                        error_bad_fcs <= fcs_bad;
                    end else begin
                        error_short_frame <= 1'b1;
                    end
                    crc_state <= 32'hFFFFFFFF;
                    cnt       <= 3'd0;
                end
            end
        end
    end

endmodule
